// File: rtl/hdbus_pkg.sv
// Shared types and defaults for the half-duplex bus endpoint.
// Parity support is compiled in only when HDBUS_PARITY_EN is defined.
package hdbus_pkg;

    typedef enum logic [1:0] {
        ST_OWN,
        ST_RELEASE,
        ST_LISTEN,
        ST_TURN_IN
    } state_t;

    localparam int DEF_W          = 5;
    localparam int DEF_TX_DEPTH   = 4;
    localparam int DEF_TURN       = 2;
    localparam int DEF_MAX_BURST  = 8;
    localparam int DEF_IDLE_REL   = 3;
    localparam int DEF_INIT_OWNER = 1;

    // Even parity bit: makes the total count of ones (data + parity) even.
    function automatic logic even_par(input logic [31:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/hdbus_txfifo.sv
// Synchronous TX FIFO with registered full/empty flags; DEPTH must be a power of two.
module hdbus_txfifo
    import hdbus_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int DEPTH = DEF_TX_DEPTH
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push_i,
    input  logic       pop_i,
    input  logic [1:W] wdata_i,
    output logic [1:W] rdata_o,
    output logic       full_o,
    output logic       empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [1:W]    mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          full_q, full_d, empty_q, empty_d;
    logic          do_push, do_pop;

    assign do_push = push_i && !full_q;
    assign do_pop  = pop_i && !empty_q;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (do_push) wptr_d = wptr_q + 1'b1;
        if (do_pop)  rptr_d = rptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        full_d  = (cnt_d == CW'(DEPTH));
        empty_d = (cnt_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rptr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/hdbus_port.sv
// Half-duplex tristate bus endpoint: sends buffered words while owning the bus, samples the peer while listening.
// Optional parity line and checker are enabled by defining HDBUS_PARITY_EN.
module hdbus_port
    import hdbus_pkg::*;
#(
    parameter int W          = DEF_W,
    parameter int TX_DEPTH   = DEF_TX_DEPTH,
    parameter int TURN       = DEF_TURN,
    parameter int MAX_BURST  = DEF_MAX_BURST,
    parameter int IDLE_REL   = DEF_IDLE_REL,
    parameter int INIT_OWNER = DEF_INIT_OWNER
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic [1:W] tx_data,
    output logic       rx_valid,
    output logic [1:W] rx_data,
    inout  wire  [1:W] bus_dat,
    inout  wire        bus_stb,
    output logic       tok_out,
    input  logic       tok_in,
    output logic       owner,
    output logic       tok_err
`ifdef HDBUS_PARITY_EN
    ,
    inout  wire        bus_par,
    output logic       par_err
`endif
);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int IW = $clog2(IDLE_REL + 1);
    localparam int TW = $clog2(TURN + 1);
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);
    localparam logic [IW-1:0] IDLE_MAX  = IW'(IDLE_REL);
    localparam logic [TW-1:0] TURN_LAST = TW'(TURN - 1);

    state_t        state_q, state_d;
    logic [BW-1:0] burst_q, burst_d;
    logic [IW-1:0] idle_q, idle_d;
    logic [TW-1:0] turn_q, turn_d;
    logic          oe_q, oe_d, stb_q, stb_d;
    logic [1:W]    dat_q, dat_d;
    logic          rx_valid_q, rx_valid_d;
    logic [1:W]    rx_data_q, rx_data_d;
    logic          tok_err_q, tok_err_d;
    logic          fifo_full, fifo_empty, push, pop, rx_ok;
    logic [1:W]    fifo_head;

    // Core handshake: a word transfers on a cycle where tx_valid && tx_ready;
    // tx_ready is the registered not-full flag, so it ignores a same-cycle pop.
    assign tx_ready = !fifo_full && !rst;
    assign push     = tx_valid && tx_ready;

    hdbus_txfifo #(.W(W), .DEPTH(TX_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (tx_data),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

`ifdef HDBUS_PARITY_EN
    logic par_q, par_d, par_err_q, par_err_d;
    assign rx_ok   = (even_par(32'(bus_dat)) == bus_par);
    assign bus_par = oe_q ? par_q : 1'bz;
    assign par_err = par_err_q;
`else
    assign rx_ok = 1'b1;
`endif

    always_comb begin
        state_d    = state_q;
        burst_d    = burst_q;
        idle_d     = idle_q;
        turn_d     = '0;
        oe_d       = 1'b0;
        stb_d      = 1'b0;
        dat_d      = '0;
        rx_valid_d = 1'b0;
        rx_data_d  = rx_data_q;
        tok_err_d  = tok_err_q;
        pop        = 1'b0;
`ifdef HDBUS_PARITY_EN
        par_d      = 1'b0;
        par_err_d  = par_err_q;
`endif
        case (state_q)
            ST_OWN: begin
                oe_d = 1'b1;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    stb_d   = 1'b1;
                    dat_d   = fifo_head;
                    burst_d = burst_q + 1'b1;
                    idle_d  = '0;
`ifdef HDBUS_PARITY_EN
                    par_d   = even_par(32'(fifo_head));
`endif
                end else begin
                    idle_d = idle_q + 1'b1;
                end
                if (burst_d == BURST_MAX || idle_d == IDLE_MAX) state_d = ST_RELEASE;
                if (tok_in) tok_err_d = 1'b1;
            end
            // oe_d stays 0 here, so the last word is still driven this cycle and the bus frees next cycle.
            ST_RELEASE: begin
                state_d = ST_LISTEN;
                if (tok_in) tok_err_d = 1'b1;
            end
            ST_LISTEN: begin
                if (bus_stb == 1'b1) begin
                    if (rx_ok) begin
                        rx_valid_d = 1'b1;
                        rx_data_d  = bus_dat;
                    end
`ifdef HDBUS_PARITY_EN
                    else par_err_d = 1'b1;
`endif
                end
                if (tok_in) state_d = ST_TURN_IN;
            end
            ST_TURN_IN: begin
                turn_d = turn_q + 1'b1;
                if (turn_q == TURN_LAST) begin
                    state_d = ST_OWN;
                    burst_d = '0;
                    idle_d  = '0;
                end
            end
            default: state_d = ST_LISTEN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= (INIT_OWNER == 1) ? ST_TURN_IN : ST_LISTEN;
            burst_q    <= '0;
            idle_q     <= '0;
            turn_q     <= '0;
            oe_q       <= 1'b0;
            stb_q      <= 1'b0;
            dat_q      <= '0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
            tok_err_q  <= 1'b0;
`ifdef HDBUS_PARITY_EN
            par_q      <= 1'b0;
            par_err_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            burst_q    <= burst_d;
            idle_q     <= idle_d;
            turn_q     <= turn_d;
            oe_q       <= oe_d;
            stb_q      <= stb_d;
            dat_q      <= dat_d;
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
            tok_err_q  <= tok_err_d;
`ifdef HDBUS_PARITY_EN
            par_q      <= par_d;
            par_err_q  <= par_err_d;
`endif
        end
    end

    assign bus_dat  = oe_q ? dat_q : {W{1'bz}};
    assign bus_stb  = oe_q ? stb_q : 1'bz;
    assign tok_out  = (state_q == ST_RELEASE);
    assign owner    = (state_q == ST_OWN);
    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;
    assign tok_err  = tok_err_q;

endmodule
